// File: rtl/sobel_controlador.sv
// Sobel 3x3 edge-magnitude custom-instruction controller.
// Build option: SOBEL_THRESHOLD_EN (binarise output against dataa[7:0]).
module sobel_controlador (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, LOAD, CALC_X, CALC_Y, MAG, DONE
  } state_t;

  state_t             state_q, state_d;
  logic        [3:0]  cnt_q, cnt_d;
  logic signed [11:0] gx_q, gx_d;
  logic signed [11:0] gy_q, gy_d;
  logic        [7:0]  pix_q [9];
  logic        [7:0]  pix_d [9];
  logic        [31:0] last_q, last_d;
  logic        [31:0] res_q, res_d;
`ifdef SOBEL_THRESHOLD_EN
  logic        [7:0]  thr_q, thr_d;
`endif

  logic               ydir;
  logic        [2:0]  cf;
  logic        [7:0]  cur;
  logic        [9:0]  prod;
  logic signed [11:0] term;
  logic signed [11:0] acc_in;
  logic signed [11:0] acc_out;
  logic        [11:0] ax;
  logic        [11:0] ay;
  logic        [11:0] msum;
  logic        [7:0]  sat;
  logic        [7:0]  pixel;
  logic               unused_in;

  assign unused_in = ^{dataa, datab};

  // {negate, magnitude} of the kernel tap k for the X or Y kernel
  function automatic logic [2:0] coef(
    input logic       y,
    input logic [3:0] k
  );
    logic [2:0] c;
    c = 3'b000;
    if (!y) begin
      case (k)
        4'd0, 4'd6: c = 3'b101;
        4'd2, 4'd8: c = 3'b001;
        4'd3:       c = 3'b110;
        4'd5:       c = 3'b010;
        default:    c = 3'b000;
      endcase
    end else begin
      case (k)
        4'd0, 4'd2: c = 3'b101;
        4'd1:       c = 3'b110;
        4'd6, 4'd8: c = 3'b001;
        4'd7:       c = 3'b010;
        default:    c = 3'b000;
      endcase
    end
    return c;
  endfunction

  // shift-add datapath: one tap per cycle plus the magnitude stage
  always_comb begin
    ydir    = (state_q == CALC_Y);
    cf      = coef(ydir, cnt_q);
    cur     = (cnt_q <= 4'd8) ? pix_q[cnt_q] : 8'd0;
    prod    = 10'd0;
    if (cf[1:0] == 2'd1) prod = {2'b00, cur};
    if (cf[1:0] == 2'd2) prod = {1'b0, cur, 1'b0};
    term    = signed'({2'b00, prod});
    acc_in  = ydir ? gy_q : gx_q;
    acc_out = cf[2] ? (acc_in - term) : (acc_in + term);
    ax      = gx_q[11] ? 12'(-gx_q) : 12'(gx_q);
    ay      = gy_q[11] ? 12'(-gy_q) : 12'(gy_q);
    msum    = ax + ay;
    sat     = (msum > 12'd255) ? 8'hFF : msum[7:0];
`ifdef SOBEL_THRESHOLD_EN
    pixel   = (sat >= thr_q) ? 8'hFF : 8'h00;
`else
    pixel   = sat;
`endif
  end

  // next-state, window/accumulator updates and outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    pix_d   = pix_q;
    last_d  = last_q;
    res_d   = res_q;
`ifdef SOBEL_THRESHOLD_EN
    thr_d   = thr_q;
`endif
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    result  = (state_q == DONE) ? res_q : 32'd0;
    if (clk_en) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            unique case (n)
              2'd0: begin
                // load commits at acceptance so done lands next cycle
                for (int i = 0; i < 9; i++)
                  if (dataa[3:0] == 4'(i)) pix_d[i] = datab[7:0];
                res_d = (dataa[3:0] <= 4'd8) ?
                        {28'd0, dataa[3:0]} : 32'hFFFF_FFFF;
                state_d = DONE;
              end
              2'd1: begin
                gx_d    = '0;
                gy_d    = '0;
                cnt_d   = '0;
`ifdef SOBEL_THRESHOLD_EN
                thr_d   = dataa[7:0];
`endif
                state_d = CALC_X;
              end
              2'd2: begin
                res_d   = last_q;
                state_d = DONE;
              end
              2'd3: begin
                for (int i = 0; i < 9; i++) pix_d[i] = 8'd0;
                res_d   = 32'd0;
                state_d = DONE;
              end
            endcase
          end
        end
        LOAD: state_d = DONE;
        CALC_X: begin
          gx_d  = acc_out;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd8) begin
            cnt_d   = '0;
            state_d = CALC_Y;
          end
        end
        CALC_Y: begin
          gy_d  = acc_out;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd8) begin
            cnt_d   = '0;
            state_d = MAG;
          end
        end
        MAG: begin
          res_d   = {24'd0, pixel};
          last_d  = {24'd0, pixel};
          state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // state registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      last_q  <= '0;
      res_q   <= '0;
      for (int i = 0; i < 9; i++) pix_q[i] <= '0;
`ifdef SOBEL_THRESHOLD_EN
      thr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      last_q  <= last_d;
      res_q   <= res_d;
      for (int i = 0; i < 9; i++) pix_q[i] <= pix_d[i];
`ifdef SOBEL_THRESHOLD_EN
      thr_q   <= thr_d;
`endif
    end
  end

endmodule

// File: tb/tb_sobel_controlador.sv
// Directed self-checking bench for sobel_controlador.
// Threshold checks follow SOBEL_THRESHOLD_EN when defined.
module tb_sobel_controlador;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic        start;
  logic [1:0]  n;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;
  logic        busy;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  sobel_controlador dut (
    .clk    (clk),
    .reset_n(reset_n),
    .clk_en (clk_en),
    .start  (start),
    .n      (n),
    .dataa  (dataa),
    .datab  (datab),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  task automatic op(
    input  logic [1:0]  op_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          lat,
    output logic [31:0] res
  );
    @(negedge clk);
    start = 1'b1; n = op_n; dataa = a; datab = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    res = 32'hDEAD_BEEF;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        res = result;
        break;
      end
    end
  endtask

  task automatic launch(input logic [1:0] op_n);
    @(negedge clk);
    start = 1'b1; n = op_n; dataa = 0; datab = 0;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset;
    int lat; logic [31:0] r;
    reset_n = 1'b0; clk_en = 1'b1; start = 1'b0;
    n = 2'd0; dataa = 0; datab = 0;
    repeat (3) @(negedge clk);
    total++;
    if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done);
    else pass_cnt++;
    total++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
    else pass_cnt++;
    total++;
    if (result !== 32'd0) $display("FAIL rst_result got %h want 0", result);
    else pass_cnt++;
    reset_n = 1'b1;
    op(2'd2, 0, 0, lat, r);
    total++;
    if (lat !== 1 || r !== 32'd0)
      $display("FAIL rst_read got lat %0d res %h want lat 1 res 0", lat, r);
    else pass_cnt++;
  endtask

  task automatic test_uniform;
    int lat; logic [31:0] r;
    for (int i = 0; i < 9; i++) op(2'd0, i, 100, lat, r);
    total++;
    if (lat !== 1 || r !== 32'd8)
      $display("FAIL load_idx8 got lat %0d res %h want lat 1 res 8", lat, r);
    else pass_cnt++;
    op(2'd1, 0, 0, lat, r);
    total++;
    if (lat !== 20 || r !== 32'd0)
      $display("FAIL uniform got lat %0d res %h want lat 20 res 0", lat, r);
    else pass_cnt++;
  endtask

  task automatic test_single;
    int lat; logic [31:0] r;
    op(2'd3, 0, 0, lat, r);
    total++;
    if (lat !== 1 || r !== 32'd0)
      $display("FAIL clear got lat %0d res %h want lat 1 res 0", lat, r);
    else pass_cnt++;
    op(2'd0, 5, 10, lat, r);
    op(2'd1, 0, 0, lat, r);
    total++;
    if (lat !== 20 || r !== 32'd20)
      $display("FAIL single got lat %0d res %h want lat 20 res 14", lat, r);
    else pass_cnt++;
    op(2'd2, 0, 0, lat, r);
    total++;
    if (lat !== 1 || r !== 32'd20)
      $display("FAIL read got lat %0d res %h want lat 1 res 14", lat, r);
    else pass_cnt++;
  endtask

  task automatic test_vertical;
    int lat; logic [31:0] r;
    op(2'd3, 0, 0, lat, r);
    op(2'd0, 2, 255, lat, r);
    op(2'd0, 5, 255, lat, r);
    op(2'd0, 8, 255, lat, r);
    op(2'd1, 0, 0, lat, r);
    total++;
    if (r !== 32'd255)
      $display("FAIL vert_sat got %h want ff", r);
    else pass_cnt++;
    op(2'd3, 0, 0, lat, r);
    op(2'd0, 7, 30, lat, r);
    op(2'd1, 0, 0, lat, r);
    total++;
    if (r !== 32'd60)
      $display("FAIL p7_gy got %h want 3c", r);
    else pass_cnt++;
  endtask

  task automatic test_ignore;
    int lat; int nd; logic [31:0] r;
    op(2'd3, 0, 0, lat, r);
    op(2'd0, 5, 10, lat, r);
    launch(2'd1);
    nd = 0; lat = -1; r = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total++;
        if (busy !== 1'b1) $display("FAIL busy_c1 got %b want 1", busy);
        else pass_cnt++;
      end
      if (c == 5) begin start = 1'b1; n = 2'd2; end
      if (c == 6) start = 1'b0;
      if (done) begin
        nd++;
        if (lat < 0) begin lat = c; r = result; end
      end
    end
    total++;
    if (nd !== 1 || lat !== 20 || r !== 32'd20)
      $display("FAIL ignore got %0d dones lat %0d res %h want 1 20 14",
               nd, lat, r);
    else pass_cnt++;
    op(2'd0, 12, 77, lat, r);
    total++;
    if (r !== 32'hFFFF_FFFF)
      $display("FAIL load_bad got %h want ffffffff", r);
    else pass_cnt++;
    op(2'd1, 0, 0, lat, r);
    total++;
    if (r !== 32'd20)
      $display("FAIL bad_nowrite got %h want 14", r);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int lat; int nd; logic [31:0] r;
    launch(2'd1);
    nd = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (c == 10) begin
        reset_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy);
        else pass_cnt++;
      end
      if (c == 14) reset_n = 1'b1;
    end
    total++;
    if (nd !== 0) $display("FAIL rst_mid_done got %0d want 0", nd);
    else pass_cnt++;
    op(2'd2, 0, 0, lat, r);
    total++;
    if (r !== 32'd0) $display("FAIL rst_mid_read got %h want 0", r);
    else pass_cnt++;
    op(2'd1, 0, 0, lat, r);
    total++;
    if (lat !== 20 || r !== 32'd0)
      $display("FAIL rst_mid_win got lat %0d res %h want 20 0", lat, r);
    else pass_cnt++;
  endtask

  task automatic test_clk_en;
    int lat; logic [31:0] r;
    op(2'd0, 5, 10, lat, r);
    launch(2'd1);
    lat = -1; r = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 5) clk_en = 1'b0;
      if (c == 9) clk_en = 1'b1;
      if (done) begin lat = c; r = result; break; end
    end
    total++;
    if (lat !== 24 || r !== 32'd20)
      $display("FAIL clk_en got lat %0d res %h want 24 14", lat, r);
    else pass_cnt++;
    launch(2'd2);
    @(negedge clk);
    total++;
    if (done !== 1'b1) $display("FAIL hold_pre got %b want 1", done);
    else pass_cnt++;
    clk_en = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (done !== 1'b1 || result !== 32'd20)
      $display("FAIL hold got done %b res %h want 1 14", done, result);
    else pass_cnt++;
    clk_en = 1'b1;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || result !== 32'd0)
      $display("FAIL hold_end got done %b res %h want 0 0", done, result);
    else pass_cnt++;
  endtask

  task automatic test_threshold;
    int lat; logic [31:0] r;
`ifdef SOBEL_THRESHOLD_EN
    op(2'd1, 20, 0, lat, r);
    total++;
    if (r !== 32'd255) $display("FAIL thr20 got %h want ff", r);
    else pass_cnt++;
    op(2'd1, 21, 0, lat, r);
    total++;
    if (r !== 32'd0) $display("FAIL thr21 got %h want 0", r);
    else pass_cnt++;
`else
    op(2'd1, 21, 0, lat, r);
    total++;
    if (r !== 32'd20) $display("FAIL nothr got %h want 14", r);
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset;
    test_uniform;
    test_single;
    test_vertical;
    test_ignore;
    test_reset_mid;
    test_clk_en;
    test_threshold;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
